// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default buffer depth and
// the transmit-buffer controller state encoding.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int TX_BUF_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/transmit_buffer_ram.sv
// Simple dual-port byte RAM for the transmit buffer.
// One synchronous write port, one synchronous read port, no reset.
module tx_buf_ram
    import uart_pkg::*;
#(
    parameter int ADDR_W = TX_BUF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [2**ADDR_W];
    logic [BYTE_W-1:0] rdata_q;

    // Storage write and registered read, one cycle read latency
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/transmit_buffer.sv
// Circular byte buffer between the host and the UART transmitter.
// Optional sticky overflow flag enabled by defining TX_BUF_OVF_EN.
module transmit_buffer
    import uart_pkg::*;
#(
    parameter int ADDR_W = TX_BUF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    input  logic              tx_busy_i,
    output logic              tx_start_o,
    output logic [BYTE_W-1:0] tx_data_o
`ifdef TX_BUF_OVF_EN
    ,
    output logic              ovf_o,
    input  logic              ovf_clr_i
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [BYTE_W-1:0] ram_rdata;
    logic              wr_acc;
    logic              pop;

    // Flags decode from the registered count only
    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Accepted write, pop and pointer/count next values
    always_comb begin
        wr_acc   = wr_en_i && !full_o;
        pop      = (state_q == LOAD);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Controller next state and transmitter handshake outputs
    always_comb begin
        state_d    = state_q;
        tx_start_o = 1'b0;
        tx_data_o  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (!empty_o) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                tx_start_o = 1'b1;
                tx_data_o  = ram_rdata;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tx_data_d = tx_data_o;
    end

    // Controller, pointer, count and output data registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef TX_BUF_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a dropped write beats a simultaneous clear
    always_comb begin
        ovf_d = (ovf_q && !ovf_clr_i) || (wr_en_i && full_o);
    end

    // Overflow flag register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    tx_buf_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_transmit_buffer.sv
// Directed bench for transmit_buffer: vector table plus
// hand sequences for wrap, full/overflow, push/pop and reset.
module tb_transmit_buffer;
    import uart_pkg::*;

    localparam int AW = 8;
    localparam int NV = 24;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       b;
        int         cnt;
        logic       emp;
        logic       st;
        logic [7:0] dat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          busy_drv = 1'b0;
    logic          busy_m;
    logic          model_en = 1'b0;
    logic          busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          start;
    logic [7:0]    txd;
`ifdef TX_BUF_OVF_EN
    logic          ovf;
    logic          ovf_clr = 1'b0;
`endif

    int total = 0;
    int passed = 0;
    int bleft;
    logic [7:0] rx_q[$];
    vec_t vt[NV];

    assign busy = model_en ? busy_m : busy_drv;

    always #5 clk = ~clk;

    transmit_buffer #(
        .ADDR_W (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .tx_busy_i  (busy),
        .tx_start_o (start),
        .tx_data_o  (txd)
`ifdef TX_BUF_OVF_EN
        ,
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr)
`endif
    );

    // Transmitter model: busy for 3 cycles after each start
    always @(negedge clk) begin
        if (!model_en) begin
            busy_m <= 1'b0;
            bleft  <= 0;
        end else if (start) begin
            rx_q.push_back(txd);
            busy_m <= 1'b1;
            bleft  <= 3;
        end else if (bleft > 0) begin
            bleft <= bleft - 1;
            if (bleft == 1) busy_m <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic b);
        @(negedge clk);
        wr_en    = w;
        wr_data  = d;
        busy_drv = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        busy_drv = 1'b0;
        model_en = 1'b0;
`ifdef TX_BUF_OVF_EN
        ovf_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int guard;
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vt[2] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'hA5};
        for (int i = 3; i <= 12; i++)
            vt[i] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'hA5};
        for (int i = 13; i <= 15; i++)
            vt[i] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'hA5};
        vt[16] = '{1'b1, 8'h3C, 1'b0, 1, 1'b0, 1'b0, 8'hA5};
        vt[17] = '{1'b1, 8'hC3, 1'b0, 2, 1'b0, 1'b0, 8'hA5};
        vt[18] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h3C};
        vt[19] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h3C};
        vt[20] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h3C};
        vt[21] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h3C};
        vt[22] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h3C};
        vt[23] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'hC3};

        // reset values
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_data", 32'(txd), 0);
`ifdef TX_BUF_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        do_reset();

        // vector table: single byte then two back-to-back bytes
        for (int i = 0; i < NV; i++) begin
            step(vt[i].wr, vt[i].d, vt[i].b);
            chk($sformatf("v%0d_count", i), 32'(count), vt[i].cnt);
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full), 0);
            chk($sformatf("v%0d_start", i), 32'(start), 32'(vt[i].st));
            chk($sformatf("v%0d_data", i), 32'(txd), 32'(vt[i].dat));
        end

        // burst of 300 bytes with wrap-around, paced by full
        do_reset();
        model_en = 1'b1;
        n = 0;
        guard = 0;
        while (n < 300 && guard < 5000) begin
            @(negedge clk);
            if (!full) begin
                wr_en   = 1'b1;
                wr_data = 8'(n);
                n++;
            end else begin
                wr_en = 1'b0;
            end
            guard++;
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 20000 && rx_q.size() < 300; c++)
            @(posedge clk);
        chk("burst_count", 32'(rx_q.size()), 300);
        for (int i = 0; i < rx_q.size() && i < 300; i++)
            chk($sformatf("burst_%0d", i), 32'(rx_q[i]), 32'(i % 256));
        repeat (8) @(posedge clk);
        #1;
        chk("burst_empty", 32'(empty), 1);

        // fill to capacity with the transmitter stuck busy
        do_reset();
        for (int i = 0; i < 257; i++) step(1'b1, 8'(i + 1), 1'b1);
        chk("full_count", 32'(count), 256);
        chk("full_flag", 32'(full), 1);
        chk("full_data", 32'(txd), 32'h01);
`ifdef TX_BUF_OVF_EN
        chk("ovf_before", 32'(ovf), 0);
`endif
        step(1'b1, 8'hEE, 1'b1);
        chk("drop_count", 32'(count), 256);
        chk("drop_full", 32'(full), 1);
`ifdef TX_BUF_OVF_EN
        chk("ovf_set", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        chk("ovf_clr", 32'(ovf), 0);
        step(1'b1, 8'hAA, 1'b1);
        chk("ovf_set_wins", 32'(ovf), 1);
        ovf_clr = 1'b0;
`endif

        // push and pop in the same cycle with count 5
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 + i), 1'b1);
        chk("pp_fill", 32'(count), 5);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("pp_pre", 32'(count), 5);
        step(1'b1, 8'h20, 1'b0);
        chk("pp_count", 32'(count), 5);
        chk("pp_start", 32'(start), 1);
        chk("pp_data", 32'(txd), 32'h12);

        // reset while waiting for the transmitter to finish
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
        chk("mid_count", 32'(count), 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_data", 32'(txd), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        busy_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk($sformatf("post_rst_start%0d", i), 32'(start), 0);
        end
        chk("post_rst_count", 32'(count), 0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_nostart", 32'(start), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_start", 32'(start), 1);
        chk("post_rst_data", 32'(txd), 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
